spi_txn_sequencer: RTL and testbench
====================================

Name: spi_txn_sequencer

Overview:
- Multi-byte transaction controller that sits between a host/register block and the single-byte SPI master.
- Owns chip-select timing: setup, hold and minimum deassert gap.
- Streams host TX bytes into the master one at a time and returns each received byte to the host.
- The master shares the same i_Clk/i_Rst.

Parameters:
LEN_W, 8, width of byte-count field; max transaction length 2^LEN_W-1 bytes
CS_SETUP_CLKS, 2, i_Clk cycles from o_CS_n falling to first byte launch (min 1)
CS_HOLD_CLKS, 2, i_Clk cycles from last RX byte to o_CS_n rising (min 1)
CS_IDLE_CLKS, 2, minimum i_Clk cycles o_CS_n stays high before the next transaction (min 1)

Ports:
i_Clk  in  1  clock
i_Rst  in  1  reset, asynchronous, active-high
i_Start  in  1  start pulse; sampled only in IDLE
i_Len  in  LEN_W  byte count, sampled with i_Start
i_Abort  in  1  level; ends the transaction at the next byte boundary
o_Busy  out  1  high in every state except IDLE
o_Done  out  1  one-cycle pulse when the transaction completes or is aborted
i_Byte_Valid  in  1  host TX byte available
i_Byte  in  8  host TX byte
o_Byte_Ready  out  1  combinational; a byte is consumed when valid&ready
o_RX_Valid  out  1  one-cycle pulse, received byte valid
o_RX_Byte  out  8  received byte
o_RX_Last  out  1  high together with o_RX_Valid for the final byte
o_M_TX_Byte  out  8  to SPI master byte input
o_M_TX_Valid  out  1  to SPI master valid input; one-cycle pulse
i_M_TX_Ready  in  1  from SPI master ready
i_M_RX_Valid  in  1  from SPI master RX valid
i_M_RX_Byte  in  8  from SPI master RX byte
o_CS_n  out  1  chip select, active-low, registered

Behaviour:
- Reset values: o_CS_n=1, o_Busy=0, o_Done=0, o_M_TX_Valid=0, o_M_TX_Byte=0, o_RX_Valid=0, o_RX_Byte=0, o_RX_Last=0, state=IDLE, counters=0.
- Reset mid-transaction drops o_CS_n high immediately (asynchronous); no o_Done is generated.
- States: IDLE, CS_SETUP, LOAD, XFER, CS_HOLD, CS_GAP.
- IDLE:
  - i_Start with i_Len!=0: latch remaining=i_Len, o_CS_n<=0, go to CS_SETUP.
  - i_Start with i_Len==0: ignored; no CS activity and no o_Done.
- CS_SETUP: count CS_SETUP_CLKS cycles, then go to LOAD.
- LOAD:
  - o_Byte_Ready = i_M_TX_Ready & ~i_Abort.
  - On i_Byte_Valid & o_Byte_Ready: o_M_TX_Byte<=i_Byte, o_M_TX_Valid<=1 for exactly one cycle, go to XFER.
  - Host not valid: stall indefinitely with CS held low.
  - i_Abort high: go to CS_HOLD without launching a byte.
- XFER:
  - o_Byte_Ready=0. Wait for i_M_RX_Valid.
  - On i_M_RX_Valid: o_RX_Byte<=i_M_RX_Byte, o_RX_Valid<=1 (next cycle, one cycle wide), remaining<=remaining-1.
  - o_RX_Last<=1 when remaining==1 or i_Abort.
  - Next state: CS_HOLD if remaining==1 or i_Abort, else LOAD.
  - An abort during XFER completes the in-flight byte first.
- LOAD after XFER must wait for i_M_TX_Ready to rise again; the master raises it after its final SCLK edge, which can come after RX valid.
- CS_HOLD: count CS_HOLD_CLKS cycles, then o_CS_n<=1, o_Done<=1 (one cycle), go to CS_GAP.
- CS_GAP: count CS_IDLE_CLKS cycles, then go to IDLE. i_Start is ignored here; o_Busy stays 1.
- Only one byte is ever outstanding in the master; o_M_TX_Valid never asserts outside the LOAD->XFER transition.
- remaining is LEN_W bits wide and never wraps: decrement happens only when remaining>=1.
- Same-cycle i_M_RX_Valid and i_Abort: the byte is delivered with o_RX_Last=1, then CS_HOLD.
- o_Busy=0 only in IDLE.

Test Plan:
1. i_Len=3, host supplies A5,3C,FF; master loopback MISO=MOSI -> o_CS_n low ≥2 cycles before first o_M_TX_Valid; exactly three o_M_TX_Valid pulses carrying A5,3C,FF; o_RX_Byte A5,3C,FF with o_RX_Last only on FF; o_CS_n high 2 cycles after last RX; single o_Done.
2. i_Len=0 with i_Start -> o_CS_n stays 1, o_Busy stays 0, no o_Done, no master activity.
3. i_Len=4, host withholds i_Byte_Valid for 50 cycles before byte 2 -> o_CS_n stays low throughout the stall; no extra o_M_TX_Valid; all 4 bytes delivered in order.
4. i_Len=5, assert i_Abort during the second byte's XFER -> second byte completes with o_RX_Last=1, no third o_M_TX_Valid, CS rises after hold, o_Done pulses.
5. i_Rst asserted mid-byte during transaction 1 -> o_CS_n=1 and all outputs at reset values the same cycle; after release, a new i_Len=1 transaction completes normally.
6. Back-to-back: i_Start held high continuously, i_Len=1 -> o_CS_n high for ≥CS_IDLE_CLKS (2) cycles between transactions; i_Start ignored during CS_GAP.

Source files
------------

// File: rtl/spi_txn_sequencer.sv
// Multi-byte SPI transaction sequencer: owns chip-select setup/hold/gap timing around a single-byte master.
// Latency: first byte launches CS_SETUP_CLKS+1 cycles after start; CS rises CS_HOLD_CLKS cycles after the last RX byte.
// Backpressure: host bytes accepted only in LOAD when the master is ready; host stalls hold CS low indefinitely.
module spi_txn_sequencer #(
    parameter int LEN_W         = 8,
    parameter int CS_SETUP_CLKS = 2,
    parameter int CS_HOLD_CLKS  = 2,
    parameter int CS_IDLE_CLKS  = 2
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             i_Start,
    input  logic [LEN_W-1:0] i_Len,
    input  logic             i_Abort,
    output logic             o_Busy,
    output logic             o_Done,
    input  logic             i_Byte_Valid,
    input  logic [7:0]       i_Byte,
    output logic             o_Byte_Ready,
    output logic             o_RX_Valid,
    output logic [7:0]       o_RX_Byte,
    output logic             o_RX_Last,
    output logic [7:0]       o_M_TX_Byte,
    output logic             o_M_TX_Valid,
    input  logic             i_M_TX_Ready,
    input  logic             i_M_RX_Valid,
    input  logic [7:0]       i_M_RX_Byte,
    output logic             o_CS_n
);

    typedef enum logic [2:0] {IDLE, CS_SETUP, LOAD, XFER, CS_HOLD, CS_GAP} state_t;

    state_t           state, state_nxt;
    logic [15:0]      cnt, cnt_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic             cs_n_nxt, done_nxt, tx_vld_nxt, rx_vld_nxt, rx_last_nxt;
    logic [7:0]       tx_byte_nxt, rx_byte_nxt;

    assign o_Busy       = (state != IDLE);
    assign o_Byte_Ready = (state == LOAD) & i_M_TX_Ready & ~i_Abort;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state        <= IDLE;
            cnt          <= '0;
            remaining    <= '0;
            o_CS_n       <= 1'b1;
            o_Done       <= 1'b0;
            o_M_TX_Valid <= 1'b0;
            o_M_TX_Byte  <= '0;
            o_RX_Valid   <= 1'b0;
            o_RX_Byte    <= '0;
            o_RX_Last    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            remaining    <= remaining_nxt;
            o_CS_n       <= cs_n_nxt;
            o_Done       <= done_nxt;
            o_M_TX_Valid <= tx_vld_nxt;
            o_M_TX_Byte  <= tx_byte_nxt;
            o_RX_Valid   <= rx_vld_nxt;
            o_RX_Byte    <= rx_byte_nxt;
            o_RX_Last    <= rx_last_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        remaining_nxt = remaining;
        cs_n_nxt      = o_CS_n;
        done_nxt      = 1'b0;
        tx_vld_nxt    = 1'b0;
        tx_byte_nxt   = o_M_TX_Byte;
        rx_vld_nxt    = 1'b0;
        rx_byte_nxt   = o_RX_Byte;
        rx_last_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (i_Start && (i_Len != '0)) begin
                    remaining_nxt = i_Len;
                    cs_n_nxt      = 1'b0;
                    cnt_nxt       = '0;
                    state_nxt     = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (cnt == 16'(CS_SETUP_CLKS - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = LOAD;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            LOAD: begin
                if (i_Abort) begin
                    cnt_nxt   = '0;
                    state_nxt = CS_HOLD;
                end else if (i_Byte_Valid && o_Byte_Ready) begin
                    tx_byte_nxt = i_Byte;
                    tx_vld_nxt  = 1'b1;
                    state_nxt   = XFER;
                end
            end
            XFER: begin
                // An abort is only honoured once the in-flight byte has come back.
                if (i_M_RX_Valid) begin
                    rx_byte_nxt = i_M_RX_Byte;
                    rx_vld_nxt  = 1'b1;
                    if (remaining != '0) begin
                        remaining_nxt = remaining - 1'b1;
                    end
                    if ((remaining <= LEN_W'(1)) || i_Abort) begin
                        rx_last_nxt = 1'b1;
                        cnt_nxt     = '0;
                        state_nxt   = CS_HOLD;
                    end else begin
                        state_nxt = LOAD;
                    end
                end
            end
            CS_HOLD: begin
                if (cnt == 16'(CS_HOLD_CLKS - 1)) begin
                    cs_n_nxt  = 1'b1;
                    done_nxt  = 1'b1;
                    cnt_nxt   = '0;
                    state_nxt = CS_GAP;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            CS_GAP: begin
                if (cnt == 16'(CS_IDLE_CLKS - 1)) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_txn_sequencer.sv
// Directed bench for spi_txn_sequencer with a loopback byte-master model and a host byte feeder.
module tb_spi_txn_sequencer;
    localparam int LEN_W = 8;

    logic             clk;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             busy, done, byte_ready, rx_valid, rx_last, m_tx_valid, cs_n;
    logic [7:0]       rx_byte, m_tx_byte;
    bit               byte_valid, m_tx_ready, m_rx_valid;
    bit   [7:0]       byte_dat, m_rx_byte;

    spi_txn_sequencer #(.LEN_W(LEN_W), .CS_SETUP_CLKS(2), .CS_HOLD_CLKS(2), .CS_IDLE_CLKS(2)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Start(start), .i_Len(len), .i_Abort(abort),
        .o_Busy(busy), .o_Done(done), .i_Byte_Valid(byte_valid), .i_Byte(byte_dat),
        .o_Byte_Ready(byte_ready), .o_RX_Valid(rx_valid), .o_RX_Byte(rx_byte), .o_RX_Last(rx_last),
        .o_M_TX_Byte(m_tx_byte), .o_M_TX_Valid(m_tx_valid), .i_M_TX_Ready(m_tx_ready),
        .i_M_RX_Valid(m_rx_valid), .i_M_RX_Byte(m_rx_byte), .o_CS_n(cs_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total, bad;
    logic [7:0] e[$];
    logic [7:0] nxt_host[$];
    int nxt_stall, clr_cnt;

    logic [7:0] tx_q[$], rx_q[$], last_q[$], host_q[$];
    int clr_seen, n_done, tx_bad, cs_falls, gap_min, setup_seen, hold_seen, low_at_rise;
    int cs_low_run, cs_high_run, since_last, host_idx, stall_idx, host_wait, m_cnt;
    bit had_rise, first_pending, prev_cs, busy_seen;
    bit [7:0] m_sh;

    // Monitor, master model and host feeder share one process so their ordering is fixed.
    always @(negedge clk) begin
        if (clr_cnt != clr_seen) begin
            clr_seen = clr_cnt;
            tx_q.delete(); rx_q.delete(); last_q.delete();
            host_q = nxt_host; stall_idx = nxt_stall;
            n_done = 0; tx_bad = 0; cs_falls = 0; gap_min = 1000; setup_seen = -1;
            hold_seen = -1; low_at_rise = 0; had_rise = 0; busy_seen = 0;
            host_idx = 0; host_wait = 0;
        end
        if (m_tx_valid) begin
            tx_q.push_back(m_tx_byte);
            if (cs_n || !m_tx_ready) tx_bad++;
            if (first_pending) begin setup_seen = cs_low_run; first_pending = 0; end
        end
        if (rx_valid) begin
            rx_q.push_back(rx_byte);
            last_q.push_back({7'd0, rx_last});
            if (rx_last) since_last = 0;
        end
        if (done) n_done++;
        if (busy) busy_seen = 1;
        if (!cs_n) begin
            if (prev_cs) begin
                cs_falls++;
                if (had_rise && cs_high_run < gap_min) gap_min = cs_high_run;
                first_pending = 1;
                cs_low_run = 0;
            end
            cs_low_run++;
        end else begin
            if (!prev_cs) begin
                had_rise = 1; hold_seen = since_last; low_at_rise = cs_low_run; cs_high_run = 0;
            end
            cs_high_run++;
        end
        since_last++;
        prev_cs = cs_n;

        m_rx_valid = 0;
        if (rst) begin
            m_cnt = 0; m_tx_ready = 1;
        end else if (m_cnt == 0) begin
            if (m_tx_valid && m_tx_ready) begin m_sh = m_tx_byte; m_tx_ready = 0; m_cnt = 1; end
        end else begin
            m_cnt++;
            if (m_cnt == 8) begin m_rx_valid = 1; m_rx_byte = m_sh; end
            // Ready comes back two cycles after RX valid, like a master finishing its last SCLK edge.
            if (m_cnt == 10) begin m_tx_ready = 1; m_cnt = 0; end
        end

        if (m_tx_valid && host_q.size() > 0) begin
            void'(host_q.pop_front());
            host_idx++;
            if (host_idx == stall_idx) host_wait = 50;
        end
        if (host_wait > 0) begin
            byte_valid = 0; host_wait--;
        end else if (host_q.size() > 0) begin
            byte_valid = 1; byte_dat = host_q[0];
        end else begin
            byte_valid = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_q(input string tag, input int sel);
        logic [7:0] q[$];
        case (sel)
            0:       q = tx_q;
            1:       q = rx_q;
            default: q = last_q;
        endcase
        chk({tag, "_len"}, q.size(), e.size());
        for (int i = 0; i < e.size(); i++)
            chk(tag, (i < q.size()) ? {24'd0, q[i]} : 32'hDEAD, {24'd0, e[i]});
    endtask

    task automatic load(input int stall);
        nxt_host = e; nxt_stall = stall; clr_cnt++;
        tick(); tick();
    endtask

    task automatic pulse(input int l);
        start = 1; len = LEN_W'(l);
        tick();
        start = 0;
        tick();
    endtask

    task automatic wait_done(input int n, input int budget);
        int k = 0;
        while (n_done < n && k < budget) begin tick(); k++; end
        chk("done_timeout", n_done >= n, 1);
    endtask

    task automatic wait_tx(input int n, input int budget);
        int k = 0;
        while (tx_q.size() < n && k < budget) begin tick(); k++; end
        chk("tx_timeout", tx_q.size() >= n, 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1; start = 0; len = '0; abort = 0;
        nxt_host.delete(); nxt_stall = -1; clr_cnt = 1;
        repeat (3) tick();
        chk("rst_cs_n", cs_n, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_txv", m_tx_valid, 0);
        chk("rst_txb", m_tx_byte, 0);
        chk("rst_rxv", rx_valid, 0);
        chk("rst_rxb", rx_byte, 0);
        chk("rst_last", rx_last, 0);
        rst = 0;
        tick();

        // Three-byte loopback transaction
        e = {8'hA5, 8'h3C, 8'hFF};
        load(-1);
        pulse(3);
        wait_done(1, 400);
        repeat (6) tick();
        chk_q("t1_tx", 0);
        chk_q("t1_rx", 1);
        e = {8'h00, 8'h00, 8'h01};
        chk_q("t1_last", 2);
        chk("t1_setup", setup_seen >= 2, 1);
        chk("t1_hold", hold_seen, 2);
        chk("t1_done", n_done, 1);
        chk("t1_txbad", tx_bad, 0);
        chk("t1_busy_end", busy, 0);

        // Zero-length start is ignored
        e.delete();
        load(-1);
        pulse(0);
        repeat (20) tick();
        chk("t2_falls", cs_falls, 0);
        chk("t2_busy", busy_seen, 0);
        chk("t2_done", n_done, 0);
        chk("t2_tx", tx_q.size(), 0);

        // Host stall of 50 cycles before the second byte
        e = {8'h11, 8'h22, 8'h33, 8'h44};
        load(1);
        pulse(4);
        wait_done(1, 600);
        repeat (6) tick();
        chk_q("t3_tx", 0);
        chk_q("t3_rx", 1);
        chk("t3_falls", cs_falls, 1);
        chk("t3_low_long", low_at_rise > 50, 1);
        chk("t3_done", n_done, 1);
        chk("t3_txbad", tx_bad, 0);

        // Abort during the second byte's transfer
        e = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        load(-1);
        pulse(5);
        wait_tx(2, 300);
        abort = 1;
        wait_done(1, 300);
        abort = 0;
        repeat (6) tick();
        e = {8'h01, 8'h02};
        chk_q("t4_tx", 0);
        chk_q("t4_rx", 1);
        e = {8'h00, 8'h01};
        chk_q("t4_last", 2);
        chk("t4_hold", hold_seen, 2);
        chk("t4_done", n_done, 1);
        chk("t4_cs_n", cs_n, 1);

        // Reset in the middle of a byte
        e = {8'hA1, 8'hA2, 8'hA3};
        load(-1);
        pulse(3);
        wait_tx(1, 300);
        repeat (3) tick();
        rst = 1;
        #1;
        chk("t5_cs_n", cs_n, 1);
        chk("t5_busy", busy, 0);
        chk("t5_txv", m_tx_valid, 0);
        chk("t5_txb", m_tx_byte, 0);
        chk("t5_rxv", rx_valid, 0);
        chk("t5_last", rx_last, 0);
        chk("t5_rdy", byte_ready, 0);
        tick(); tick();
        chk("t5_nodone", n_done, 0);
        rst = 0;
        tick();
        e = {8'h5A};
        load(-1);
        pulse(1);
        wait_done(1, 300);
        repeat (6) tick();
        chk_q("t5_tx", 0);
        chk_q("t5_rx", 1);
        e = {8'h01};
        chk_q("t5_last", 2);
        chk("t5_done", n_done, 1);

        // Start held high: back-to-back single-byte transactions
        e = {8'hC1, 8'hC2, 8'hC3};
        load(-1);
        start = 1; len = LEN_W'(1);
        wait_done(3, 600);
        start = 0;
        repeat (8) tick();
        chk("t6_done", n_done, 3);
        chk("t6_falls", cs_falls, 3);
        chk_q("t6_tx", 0);
        chk_q("t6_rx", 1);
        chk("t6_gap", (gap_min >= 2) && (gap_min <= 3), 1);
        chk("t6_txbad", tx_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
